// File: rtl/serial_sub32.sv
// Bit-serial subtractor: one full-subtractor cell processes operands LSB first, one bit per clock.
// Optional signed flags (neg_o, ovf_o) are enabled with `define SERIAL_SUB_SIGNED_FLAGS_EN.
module serial_sub32 #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zero_o,
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
    output logic             neg_o,
    output logic             ovf_o,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake: start_i is accepted on a rising edge while idle or done;
    // valid_o pulses for exactly one cycle when diff_o/borrow_o/zero_o update.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               bor;
    logic [CNT_W-1:0]   cnt;
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
    logic               a_msb;
    logic               b_msb;
`endif

    logic               d_bit;
    logic               bor_next;
    logic [WIDTH-1:0]   res_next;

    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ bor;
        bor_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
        res_next = {d_bit, res_sh[WIDTH-1:1]};
    end

    assign dbg_state = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            bor      <= 1'b0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            zero_o   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            neg_o    <= 1'b0;
            ovf_o    <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        bor    <= borrow_i;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
                        a_msb  <= a_i[WIDTH-1];
                        b_msb  <= b_i[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    bor    <= bor_next;
                    cnt    <= cnt + CNT_W'(1);
                    // Result registers load on the last bit so valid_o is high during DONE.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        diff_o   <= res_next;
                        borrow_o <= bor_next;
                        zero_o   <= (res_next == '0);
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
                        neg_o    <= d_bit;
                        ovf_o    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub32.sv
// Self-checking bench for serial_sub32: directed and random subtractions against an arithmetic model.
// Define SERIAL_SUB_SIGNED_FLAGS_EN for both files to also check neg_o/ovf_o.
module tb_serial_sub32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
    logic         neg;
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // expected results: diff, borrow, zero
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_diff;

    serial_sub32 #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .a_i      (a),
        .b_i      (b),
        .borrow_i (bin),
        .busy_o   (busy),
        .valid_o  (valid),
        .diff_o   (diff),
        .borrow_o (bout),
        .zero_o   (zero),
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
        .neg_o    (neg),
        .ovf_o    (ovf),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: plain modulo arithmetic and signed range check.
    task automatic model_push(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        logic [W:0]      wide;
        longint          sres;
        logic            m_ovf;
        wide  = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
        sres  = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
        m_ovf = (sres < -(64'sd1 <<< (W-1))) || (sres > ((64'sd1 <<< (W-1)) - 1));
        exp_q.push_back(wide[W-1:0]);
        exp_q.push_back(W'(wide[W]));
        exp_q.push_back(W'(wide[W-1:0] == '0));
        exp_q.push_back(W'(wide[W-1]));
        exp_q.push_back(W'(m_ovf));
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] e_diff, e_bor, e_zero, e_neg, e_ovf;
        e_diff = exp_q.pop_front();
        e_bor  = exp_q.pop_front();
        e_zero = exp_q.pop_front();
        e_neg  = exp_q.pop_front();
        e_ovf  = exp_q.pop_front();
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_diff"}, 64'(diff), 64'(e_diff));
        chk({tag, "_borrow"}, 64'(bout), 64'(e_bor));
        chk({tag, "_zero"}, 64'(zero), 64'(e_zero));
`ifdef SERIAL_SUB_SIGNED_FLAGS_EN
        chk({tag, "_neg"}, 64'(neg), 64'(e_neg));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
`else
        if (e_neg === 1'bx || e_ovf === 1'bx) chk({tag, "_model"}, 64'd0, 64'd1);
`endif
        last_diff = diff;
    endtask

    // Drive one op at a negedge, then check busy for W cycles and the result in cycle W+1.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin);
        int busy_bad;
        int valid_bad;
        busy_bad  = 0;
        valid_bad = 0;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        model_push(ta, tb, tbin);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom(); b = $urandom(); bin = 1'($urandom_range(0, 1));
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (valid !== 1'b0) valid_bad++;
        end
        chk({tag, "_busy_cycles_bad"}, 64'(busy_bad), 64'd0);
        chk({tag, "_early_valid"}, 64'(valid_bad), 64'd0);
        @(negedge clk);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_valid_pulse_end"}, 64'(valid), 64'd0);
        chk({tag, "_diff_held"}, 64'(diff), 64'(last_diff));
    endtask

    initial begin
        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(bout), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        rst = 1'b0;

        // directed arithmetic
        run_op("d_5m3", 32'd5, 32'd3, 1'b0);
        run_op("d_0m1", 32'd0, 32'd1, 1'b0);
        run_op("d_0m1b", 32'd0, 32'd1, 1'b1);
        run_op("d_eq", 32'h1234_5678, 32'h1234_5678, 1'b0);
        run_op("d_eqb", 32'h1234_5678, 32'h1234_5678, 1'b1);
        run_op("d_minm1", 32'h8000_0000, 32'd1, 1'b0);
        run_op("d_1m2", 32'd1, 32'd2, 1'b0);
        run_op("d_maxm0b", 32'hFFFF_FFFF, 32'd0, 1'b1);

        // start during RUN ignored, then held through DONE for back-to-back
        @(negedge clk);
        a = 32'd10; b = 32'd4; bin = 1'b0; start = 1'b1;
        model_push(32'd10, 32'd4, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd100; b = 32'd1; start = 1'b1;
        model_push(32'd100, 32'd1, 1'b0);
        repeat (28) @(negedge clk);
        chk("bb_busy_c32", 64'(busy), 64'd1);
        chk("bb_novalid_c32", 64'(valid), 64'd0);
        @(negedge clk);
        check_result("bb_first");
        @(negedge clk);
        chk("bb_rerun_busy", 64'(busy), 64'd1);
        chk("bb_rerun_valid", 64'(valid), 64'd0);
        chk("bb_diff_held_run", 64'(diff), 64'd6);
        start = 1'b0;
        repeat (31) @(negedge clk);
        chk("bb_busy_c65", 64'(busy), 64'd1);
        @(negedge clk);
        check_result("bb_second");

        // reset mid-op aborts with no valid
        @(negedge clk);
        a = 32'd7; b = 32'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_diff", 64'(diff), 64'd0);
        chk("mid_rst_borrow", 64'(bout), 64'd0);
        chk("mid_rst_zero", 64'(zero), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < W + 8; i++) begin
                @(negedge clk);
                if (valid !== 1'b0 || busy !== 1'b0) stray++;
            end
            chk("mid_rst_no_valid", 64'(stray), 64'd0);
        end
        run_op("d_9m9", 32'd9, 32'd9, 1'b0);

        // random operands
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra   = $urandom();
            rb   = (k % 5 == 0) ? ra : $urandom();
            rbin = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), ra, rb, rbin);
        end

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
